// File: rtl/mc8051_alu_mdu.sv
// 8051 ALU with registered results, iterative MUL/DIV (STEP bits per cycle) and decimal adjust.
// Latency: 1 cycle for single-cycle ops and DIV by zero, DW/STEP+1 cycles for MUL/DIV.
// Backpressure: none; i_start is ignored while busy, results and flags hold until the next completion.
module mc8051_alu_mdu #(
    parameter int DW   = 8,
    parameter int STEP = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_cy,
    input  logic          i_ac,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_res_lo,
    output logic [DW-1:0] o_res_hi,
    output logic          o_hi_we,
    output logic          o_cy,
    output logic          o_ac,
    output logic          o_ov,
    output logic          o_zo,
    output logic          o_pr,
    output logic          o_cy_we,
    output logic          o_ac_we,
    output logic          o_ov_we
);
    localparam int NIT = DW / STEP;
    localparam int CW  = $clog2(NIT);
    localparam logic [CW-1:0] LAST = CW'(NIT - 1);

    localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDC = 4'h1, OP_SUBB = 4'h2, OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_RL   = 4'h6, OP_RR   = 4'h7;
    localparam logic [3:0] OP_RLC  = 4'h8, OP_RRC  = 4'h9, OP_CPL  = 4'hA, OP_SWAP = 4'hB;
    localparam logic [3:0] OP_DA   = 4'hC, OP_MUL  = 4'hD, OP_DIV  = 4'hE;

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] m_q, m_d;          // multiplicand (MUL) or divisor (DIV)
    logic [DW:0]   wk_hi_q, wk_hi_d;  // partial product high / partial remainder
    logic [DW-1:0] wk_lo_q, wk_lo_d;  // multiplier bits / dividend shifting into quotient
    logic          is_div_q, is_div_d;
    logic [DW-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic          cy_q, cy_d, ac_q, ac_d, ov_q, ov_d, zo_q, zo_d, pr_q, pr_d;
    logic          cy_we_q, cy_we_d, ac_we_q, ac_we_d, ov_we_q, ov_we_d, hi_we_q, hi_we_d;

    // Single-cycle datapath
    logic          ci;
    logic [DW:0]   add_f, sub_f;
    logic          da_lo_adj, da_hi_adj;
    logic [8:0]    da_t1, da_t2;
    logic [DW-1:0] sc_lo;
    logic          sc_cy, sc_ac, sc_ov, sc_cy_we, sc_ac_we, sc_ov_we;

    // Iteration datapath
    logic [DW:0]   st_hi, rem;
    logic [DW-1:0] st_lo;
    logic          qb;

    // Carry/borrow into bit k is a[k]^b[k]^result[k], which gives AC (k=4) and OV (k=MSB).
    assign ci        = (i_op == OP_ADD) ? 1'b0 : i_cy;
    assign add_f     = {1'b0, i_a} + {1'b0, i_b} + {{DW{1'b0}}, ci};
    assign sub_f     = {1'b0, i_a} - {1'b0, i_b} - {{DW{1'b0}}, ci};
    assign da_lo_adj = (i_a[3:0] > 4'd9) || i_ac;
    assign da_t1     = {1'b0, i_a[7:0]} + (da_lo_adj ? 9'h006 : 9'h000);
    assign da_hi_adj = (da_t1[7:4] > 4'd9) || i_cy || da_t1[8];
    assign da_t2     = {1'b0, da_t1[7:0]} + (da_hi_adj ? 9'h060 : 9'h000);

    // Result and flags for the one-cycle ops; unstrobed flags keep their held values
    always_comb begin
        sc_lo    = res_lo_q;
        sc_cy    = cy_q;
        sc_ac    = ac_q;
        sc_ov    = ov_q;
        sc_cy_we = 1'b0;
        sc_ac_we = 1'b0;
        sc_ov_we = 1'b0;
        case (i_op)
            OP_ADD, OP_ADDC: begin
                sc_lo    = add_f[DW-1:0];
                sc_cy    = add_f[DW];
                sc_ac    = i_a[4] ^ i_b[4] ^ add_f[4];
                sc_ov    = i_a[DW-1] ^ i_b[DW-1] ^ add_f[DW-1] ^ add_f[DW];
                sc_cy_we = 1'b1;
                sc_ac_we = 1'b1;
                sc_ov_we = 1'b1;
            end
            OP_SUBB: begin
                sc_lo    = sub_f[DW-1:0];
                sc_cy    = sub_f[DW];
                sc_ac    = i_a[4] ^ i_b[4] ^ sub_f[4];
                sc_ov    = i_a[DW-1] ^ i_b[DW-1] ^ sub_f[DW-1] ^ sub_f[DW];
                sc_cy_we = 1'b1;
                sc_ac_we = 1'b1;
                sc_ov_we = 1'b1;
            end
            OP_AND:  sc_lo = i_a & i_b;
            OP_OR:   sc_lo = i_a | i_b;
            OP_XOR:  sc_lo = i_a ^ i_b;
            OP_RL:   sc_lo = {i_a[DW-2:0], i_a[DW-1]};
            OP_RR:   sc_lo = {i_a[0], i_a[DW-1:1]};
            OP_RLC: begin
                sc_lo    = {i_a[DW-2:0], i_cy};
                sc_cy    = i_a[DW-1];
                sc_cy_we = 1'b1;
            end
            OP_RRC: begin
                sc_lo    = {i_cy, i_a[DW-1:1]};
                sc_cy    = i_a[0];
                sc_cy_we = 1'b1;
            end
            OP_CPL:  sc_lo = ~i_a;
            OP_SWAP: sc_lo = {i_a[DW/2-1:0], i_a[DW-1:DW/2]};
            OP_DA: begin
                sc_lo      = i_a;
                sc_lo[7:0] = da_t2[7:0];
                sc_cy      = i_cy | da_t1[8] | da_t2[8];
                sc_cy_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // STEP shift-add (MUL) or restoring-divide (DIV) bit steps per cycle
    always_comb begin
        st_hi = wk_hi_q;
        st_lo = wk_lo_q;
        rem   = '0;
        qb    = 1'b0;
        for (int s = 0; s < STEP; s++) begin
            if (is_div_q) begin
                rem = {st_hi[DW-1:0], st_lo[DW-1]};
                qb  = (rem >= {1'b0, m_q});
                if (qb) rem = rem - {1'b0, m_q};
                st_lo = {st_lo[DW-2:0], qb};
                st_hi = rem;
            end else begin
                if (st_lo[0]) st_hi = st_hi + {1'b0, m_q};
                st_lo = {st_hi[0], st_lo[DW-1:1]};
                st_hi = {1'b0, st_hi[DW:1]};
            end
        end
    end

    // Next-state and registered-output update; FIN accepts a new op like IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        wk_hi_d  = wk_hi_q;
        wk_lo_d  = wk_lo_q;
        is_div_d = is_div_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        cy_d     = cy_q;
        ac_d     = ac_q;
        ov_d     = ov_q;
        zo_d     = zo_q;
        pr_d     = pr_q;
        cy_we_d  = 1'b0;
        ac_we_d  = 1'b0;
        ov_we_d  = 1'b0;
        hi_we_d  = 1'b0;
        case (state_q)
            ITER: begin
                wk_hi_d = st_hi;
                wk_lo_d = st_lo;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = FIN;
                    res_lo_d = st_lo;
                    res_hi_d = st_hi[DW-1:0];
                    cy_d     = 1'b0;
                    ov_d     = is_div_q ? 1'b0 : (st_hi[DW-1:0] != '0);
                    cy_we_d  = 1'b1;
                    ov_we_d  = 1'b1;
                    hi_we_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (i_start) begin
                    if (i_op == OP_MUL || (i_op == OP_DIV && i_b != '0)) begin
                        state_d  = ITER;
                        cnt_d    = '0;
                        is_div_d = (i_op == OP_DIV);
                        m_d      = (i_op == OP_DIV) ? i_b : i_a;
                        wk_hi_d  = '0;
                        wk_lo_d  = (i_op == OP_DIV) ? i_a : i_b;
                    end else if (i_op == OP_DIV) begin
                        state_d  = FIN;
                        res_lo_d = '1;
                        res_hi_d = i_a;
                        cy_d     = 1'b0;
                        ov_d     = 1'b1;
                        cy_we_d  = 1'b1;
                        ov_we_d  = 1'b1;
                        hi_we_d  = 1'b1;
                    end else begin
                        state_d  = FIN;
                        res_lo_d = sc_lo;
                        cy_d     = sc_cy;
                        ac_d     = sc_ac;
                        ov_d     = sc_ov;
                        cy_we_d  = sc_cy_we;
                        ac_we_d  = sc_ac_we;
                        ov_we_d  = sc_ov_we;
                    end
                end
            end
        endcase
        if (state_d == FIN) begin
            zo_d = (res_lo_d == '0);
            pr_d = ^res_lo_d;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            wk_hi_q  <= '0;
            wk_lo_q  <= '0;
            is_div_q <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            cy_q     <= 1'b0;
            ac_q     <= 1'b0;
            ov_q     <= 1'b0;
            zo_q     <= 1'b0;
            pr_q     <= 1'b0;
            cy_we_q  <= 1'b0;
            ac_we_q  <= 1'b0;
            ov_we_q  <= 1'b0;
            hi_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            wk_hi_q  <= wk_hi_d;
            wk_lo_q  <= wk_lo_d;
            is_div_q <= is_div_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            cy_q     <= cy_d;
            ac_q     <= ac_d;
            ov_q     <= ov_d;
            zo_q     <= zo_d;
            pr_q     <= pr_d;
            cy_we_q  <= cy_we_d;
            ac_we_q  <= ac_we_d;
            ov_we_q  <= ov_we_d;
            hi_we_q  <= hi_we_d;
        end
    end

    assign o_busy   = (state_q == ITER);
    assign o_done   = (state_q == FIN);
    assign o_res_lo = res_lo_q;
    assign o_res_hi = res_hi_q;
    assign o_hi_we  = hi_we_q;
    assign o_cy     = cy_q;
    assign o_ac     = ac_q;
    assign o_ov     = ov_q;
    assign o_zo     = zo_q;
    assign o_pr     = pr_q;
    assign o_cy_we  = cy_we_q;
    assign o_ac_we  = ac_we_q;
    assign o_ov_we  = ov_we_q;
endmodule

// File: tb/tb_mc8051_alu_mdu.sv
// Scoreboard bench for mc8051_alu_mdu: DW=8/STEP=1 and DW=16/STEP=2 instances.
// Stimulus pushes the reference-model result with its due cycle; monitors pop on o_done.
// Directed cases from the feature list, a mid-MUL reset, then randomized ops.
`timescale 1ns/1ps
module tb_mc8051_alu_mdu;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // DW=8 instance
    logic       p8_start = 0, p8_cy = 0, p8_ac = 0;
    logic [3:0] p8_op = 0;
    logic [7:0] p8_a = 0, p8_b = 0, p8_lo, p8_hi;
    logic       p8_busy, p8_done, p8_hi_we, p8_ocy, p8_oac, p8_oov, p8_ozo, p8_opr;
    logic       p8_cy_we, p8_ac_we, p8_ov_we;
    // DW=16 instance
    logic        p16_start = 0, p16_cy = 0, p16_ac = 0;
    logic [3:0]  p16_op = 0;
    logic [15:0] p16_a = 0, p16_b = 0, p16_lo, p16_hi;
    logic        p16_busy, p16_done, p16_hi_we, p16_ocy, p16_oac, p16_oov, p16_ozo, p16_opr;
    logic        p16_cy_we, p16_ac_we, p16_ov_we;

    mc8051_alu_mdu #(.DW(8), .STEP(1)) u8 (
        .i_clk(clk), .i_rst(rst), .i_start(p8_start), .i_op(p8_op), .i_a(p8_a), .i_b(p8_b),
        .i_cy(p8_cy), .i_ac(p8_ac), .o_busy(p8_busy), .o_done(p8_done), .o_res_lo(p8_lo),
        .o_res_hi(p8_hi), .o_hi_we(p8_hi_we), .o_cy(p8_ocy), .o_ac(p8_oac), .o_ov(p8_oov),
        .o_zo(p8_ozo), .o_pr(p8_opr), .o_cy_we(p8_cy_we), .o_ac_we(p8_ac_we), .o_ov_we(p8_ov_we));

    mc8051_alu_mdu #(.DW(16), .STEP(2)) u16 (
        .i_clk(clk), .i_rst(rst), .i_start(p16_start), .i_op(p16_op), .i_a(p16_a), .i_b(p16_b),
        .i_cy(p16_cy), .i_ac(p16_ac), .o_busy(p16_busy), .o_done(p16_done), .o_res_lo(p16_lo),
        .o_res_hi(p16_hi), .o_hi_we(p16_hi_we), .o_cy(p16_ocy), .o_ac(p16_oac), .o_ov(p16_oov),
        .o_zo(p16_ozo), .o_pr(p16_opr), .o_cy_we(p16_cy_we), .o_ac_we(p16_ac_we), .o_ov_we(p16_ov_we));

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [8:0]  flags;  // {hi_we, cy, ac, ov, zo, pr, cy_we, ac_we, ov_we}
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    // Reference model state: values the outputs should be holding
    longint m_lo[2], m_hi[2];
    bit     m_cy[2], m_ac[2], m_ov[2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t obs(input int sel);
        exp_t o;
        if (sel == 0) begin
            o.lo    = {24'd0, p8_lo};
            o.hi    = {24'd0, p8_hi};
            o.flags = {p8_hi_we, p8_ocy, p8_oac, p8_oov, p8_ozo, p8_opr, p8_cy_we, p8_ac_we, p8_ov_we};
        end else begin
            o.lo    = {16'd0, p16_lo};
            o.hi    = {16'd0, p16_hi};
            o.flags = {p16_hi_we, p16_ocy, p16_oac, p16_oov, p16_ozo, p16_opr, p16_cy_we, p16_ac_we, p16_ov_we};
        end
        o.due = cyc;
        return o;
    endfunction

    task automatic monitor_step(input int sel, input logic done, input logic [3:0] strobes);
        exp_t e, o;
        string who;
        who = (sel == 0) ? "dw8" : "dw16";
        if (done) begin
            if ((sel == 0 && q8.size() == 0) || (sel == 1 && q16.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s unexpected_done: got done=1 expected no completion (t=%0t)", who, $time);
            end else begin
                e = (sel == 0) ? q8.pop_front() : q16.pop_front();
                o = obs(sel);
                cmp({who, " res_lo"}, o.lo, e.lo);
                cmp({who, " res_hi"}, o.hi, e.hi);
                cmp({who, " flags"}, {23'd0, o.flags}, {23'd0, e.flags});
                cmp({who, " done_cycle"}, o.due, e.due);
            end
        end else begin
            cmp({who, " idle_strobes"}, {28'd0, strobes}, 32'd0);
        end
    endtask

    // Monitors: sample away from the rising edge
    always @(negedge clk) if (!rst) monitor_step(0, p8_done, {p8_hi_we, p8_cy_we, p8_ac_we, p8_ov_we});
    always @(negedge clk) if (!rst) monitor_step(1, p16_done, {p16_hi_we, p16_cy_we, p16_ac_we, p16_ov_we});

    function automatic longint sx(input longint v, input int w);
        longint one = 1;
        return (v >= (one << (w - 1))) ? v - (one << w) : v;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cyi, input logic aci);
        if (sel == 0) begin
            p8_start = st; p8_op = op; p8_a = a[7:0]; p8_b = b[7:0]; p8_cy = cyi; p8_ac = aci;
        end else begin
            p16_start = st; p16_op = op; p16_a = a[15:0]; p16_b = b[15:0]; p16_cy = cyi; p16_ac = aci;
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? p8_busy : p16_busy;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_lo[s] = 0; m_hi[s] = 0; m_cy[s] = 0; m_ac[s] = 0; m_ov[s] = 0;
        end
    endtask

    // Compute expectation, push it, issue the op; returns in the completion cycle
    task automatic issue(input int sel, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cyi, input logic aci);
        int     w, lat;
        longint one, mask, aa, bb, r, hmax, s, low;
        bit     cw, aw, ow, hw, c;
        exp_t   e;
        w    = (sel == 0) ? 8 : 16;
        one  = 1;
        mask = (one << w) - 1;
        hmax = (one << (w - 1)) - 1;
        aa   = longint'(a) & mask;
        bb   = longint'(b) & mask;
        lat  = 1;
        cw = 0; aw = 0; ow = 0; hw = 0;
        case (op)
            4'h0, 4'h1: begin
                c = (op == 4'h1) ? cyi : 1'b0;
                r = aa + bb + longint'(c);
                m_lo[sel] = r & mask;
                m_cy[sel] = (r > mask);
                m_ac[sel] = ((aa & 15) + (bb & 15) + longint'(c)) > 15;
                s = sx(aa, w) + sx(bb, w) + longint'(c);
                m_ov[sel] = (s > hmax) || (s < -hmax - 1);
                cw = 1; aw = 1; ow = 1;
            end
            4'h2: begin
                r = aa - bb - longint'(cyi);
                m_lo[sel] = r & mask;
                m_cy[sel] = (r < 0);
                m_ac[sel] = ((aa & 15) - (bb & 15) - longint'(cyi)) < 0;
                s = sx(aa, w) - sx(bb, w) - longint'(cyi);
                m_ov[sel] = (s > hmax) || (s < -hmax - 1);
                cw = 1; aw = 1; ow = 1;
            end
            4'h3: m_lo[sel] = aa & bb;
            4'h4: m_lo[sel] = aa | bb;
            4'h5: m_lo[sel] = aa ^ bb;
            4'h6: m_lo[sel] = ((aa << 1) | (aa >> (w - 1))) & mask;
            4'h7: m_lo[sel] = ((aa >> 1) | (aa << (w - 1))) & mask;
            4'h8: begin
                m_lo[sel] = ((aa << 1) | longint'(cyi)) & mask;
                m_cy[sel] = ((aa >> (w - 1)) & 1) != 0;
                cw = 1;
            end
            4'h9: begin
                m_lo[sel] = (aa >> 1) | (longint'(cyi) << (w - 1));
                m_cy[sel] = (aa & 1) != 0;
                cw = 1;
            end
            4'hA: m_lo[sel] = (~aa) & mask;
            4'hB: m_lo[sel] = ((aa << (w / 2)) | (aa >> (w / 2))) & mask;
            4'hC: begin
                low = aa & 255;
                c = 0;
                if ((low & 15) > 9 || aci) low = low + 6;
                if (low > 255) c = 1;
                low = low & 255;
                if (((low >> 4) & 15) > 9 || cyi || c) low = low + 96;
                if (low > 255) c = 1;
                low = low & 255;
                m_lo[sel] = (aa & mask & ~longint'(255)) | low;
                m_cy[sel] = cyi | c;
                cw = 1;
            end
            4'hD: begin
                r = aa * bb;
                m_lo[sel] = r & mask;
                m_hi[sel] = r >> w;
                m_cy[sel] = 0;
                m_ov[sel] = (m_hi[sel] != 0);
                cw = 1; ow = 1; hw = 1;
                lat = w / ((sel == 0) ? 1 : 2) + 1;
            end
            4'hE: begin
                if (bb == 0) begin
                    m_lo[sel] = mask;
                    m_hi[sel] = aa;
                    m_ov[sel] = 1;
                end else begin
                    m_lo[sel] = aa / bb;
                    m_hi[sel] = aa % bb;
                    m_ov[sel] = 0;
                    lat = w / ((sel == 0) ? 1 : 2) + 1;
                end
                m_cy[sel] = 0;
                cw = 1; ow = 1; hw = 1;
            end
            default: ;
        endcase
        e.lo    = 32'(m_lo[sel]);
        e.hi    = 32'(m_hi[sel]);
        e.flags = {hw, m_cy[sel], m_ac[sel], m_ov[sel], (m_lo[sel] == 0),
                   ($countones(m_lo[sel]) % 2) == 1, cw, aw, ow};
        e.due   = cyc + lat;
        if (sel == 0) q8.push_back(e); else q16.push_back(e);

        drive(sel, 1'b1, op, a, b, cyi, aci);
        @(negedge clk);
        drive(sel, 1'b0, op, a, b, cyi, aci);
        if (lat > 1) begin
            for (int k = 1; k < lat; k++) begin
                cmp((sel == 0) ? "dw8 busy_iter" : "dw16 busy_iter", {31'd0, busy_of(sel)}, 32'd1);
                // junk requests while iterating must be ignored
                drive(sel, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
                @(negedge clk);
            end
            drive(sel, 1'b0, op, a, b, cyi, aci);
            cmp((sel == 0) ? "dw8 busy_fin" : "dw16 busy_fin", {31'd0, busy_of(sel)}, 32'd0);
        end
    endtask

    task automatic check_zero(input int sel, input string name);
        exp_t o;
        o = obs(sel);
        cmp({name, " busy"}, {31'd0, busy_of(sel)}, 32'd0);
        cmp({name, " done"}, {31'd0, (sel == 0) ? p8_done : p16_done}, 32'd0);
        cmp({name, " lo"}, o.lo, 32'd0);
        cmp({name, " hi"}, o.hi, 32'd0);
        cmp({name, " flags"}, {23'd0, o.flags}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_zero(0, "dw8 reset");
        check_zero(1, "dw16 reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed DW=8 cases
        issue(0, 4'h0, 32'h7F, 32'h01, 1'b0, 1'b0);
        issue(0, 4'h2, 32'h00, 32'h01, 1'b1, 1'b0);
        issue(0, 4'h1, 32'h12, 32'h34, 1'b1, 1'b0);   // issued in the FIN cycle
        issue(0, 4'hD, 32'h50, 32'hA0, 1'b0, 1'b0);
        issue(0, 4'hE, 32'hFB, 32'h12, 1'b0, 1'b0);
        issue(0, 4'hE, 32'h3C, 32'h00, 1'b0, 1'b0);
        issue(0, 4'h0, 32'h56, 32'h45, 1'b0, 1'b0);
        issue(0, 4'hC, 32'h9B, 32'h00, 1'b0, 1'b0);
        issue(0, 4'hF, 32'h00, 32'h00, 1'b0, 1'b0);
        issue(0, 4'hB, 32'hA5, 32'h00, 1'b0, 1'b0);
        issue(0, 4'h9, 32'h81, 32'h00, 1'b1, 1'b0);

        // Reset in the middle of a MUL: aborts, no completion
        drive(0, 1'b1, 4'hD, 32'h50, 32'hA0, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 4'hD, 32'h50, 32'hA0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero(0, "dw8 midreset");
        check_zero(1, "dw16 midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(0, 4'h0, 32'h21, 32'h13, 1'b0, 1'b0);

        // Directed DW=16, STEP=2
        issue(1, 4'hD, 32'h1234, 32'h0010, 1'b0, 1'b0);
        issue(1, 4'hE, 32'hFFFF, 32'h0007, 1'b0, 1'b0);
        issue(1, 4'hC, 32'hAB9B, 32'h0000, 1'b0, 1'b0);
        issue(1, 4'hB, 32'h1234, 32'h0000, 1'b0, 1'b0);

        // Randomized ops on both instances
        for (int i = 0; i < 300; i++) begin
            int sel;
            logic [31:0] bv;
            sel = $urandom_range(0, 1);
            bv  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            issue(sel, 4'($urandom_range(0, 15)), $urandom, bv, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        cmp("dw8 pending_results", q8.size(), 32'd0);
        cmp("dw16 pending_results", q16.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
